fetch_unit: RTL and testbench

Instruction-fetch front end that produces the IF-stage bundle (instruction, pc, pc_plus4) consumed by the IF/ID pipeline register.
- Owns the PC.
- Issues requests to instruction memory over a req/gnt + rvalid handshake.
- Buffers returned words in a small in-order FIFO.
- Honours the same stall and redirect (flush) controls applied to IF/ID.
- Presents a NOP bubble whenever no valid instruction is available.

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues req/gnt fetches, buffers the
// in-order responses and presents the IF-stage bundle (a NOP bubble when empty).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        out_valid_o,
    output logic [31:0] out_instruction_o,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_pc_plus4_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0]      pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] fifo_rd;
    logic [PTR_W-1:0] fifo_wr;
    logic [PTR_W-1:0] pend_rd;
    logic [PTR_W-1:0] pend_wr;
    logic [31:0]      fifo_pc    [DEPTH];
    logic [31:0]      fifo_instr [DEPTH];
    logic [31:0]      pend_pc    [DEPTH];

    logic             fire;
    logic             rsp_keep;
    logic             fifo_pop;
    logic [CNT_W-1:0] outstanding_next;

    // Credit covers both in-flight requests and buffered words, so the FIFO cannot overflow.
    always_comb begin
        imem_req_o        = rst_n && !redirect_valid_i
                            && ((SUM_W'(outstanding) + SUM_W'(fifo_count)) < SUM_W'(DEPTH));
        imem_addr_o       = pc;
        fire              = imem_req_o && imem_gnt_i;
        rsp_keep          = imem_rvalid_i && (discard == '0) && !redirect_valid_i;
        out_valid_o       = (fifo_count != '0);
        fifo_pop          = out_valid_o && !stall_i && !redirect_valid_i;
        outstanding_next  = outstanding + CNT_W'(fire) - CNT_W'(imem_rvalid_i);
        out_instruction_o = NOP;
        out_pc_o          = '0;
        out_pc_plus4_o    = '0;
        if (out_valid_o) begin
            out_instruction_o = fifo_instr[fifo_rd];
            out_pc_o          = fifo_pc[fifo_rd];
            out_pc_plus4_o    = fifo_pc[fifo_rd] + 32'd4;
        end
    end

    // Control state: PC, credit counters and queue pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            fifo_count  <= '0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
            pend_rd     <= '0;
            pend_wr     <= '0;
        end else if (redirect_valid_i) begin
            // Everything still in flight after a redirect is wrong-path and must be dropped.
            pc          <= {redirect_pc_i[31:2], 2'b00};
            outstanding <= outstanding_next;
            discard     <= outstanding_next;
            fifo_count  <= '0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
            pend_rd     <= '0;
            pend_wr     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (fire) begin
                pc      <= pc + 32'd4;
                pend_wr <= pend_wr + PTR_W'(1);
            end
            if (imem_rvalid_i) begin
                if (discard != '0) begin
                    discard <= discard - CNT_W'(1);
                end else begin
                    pend_rd <= pend_rd + PTR_W'(1);
                end
            end
            if (rsp_keep) begin
                fifo_wr <= fifo_wr + PTR_W'(1);
            end
            if (fifo_pop) begin
                fifo_rd <= fifo_rd + PTR_W'(1);
            end
            fifo_count <= fifo_count + CNT_W'(rsp_keep) - CNT_W'(fifo_pop);
        end
    end

    // Payload storage; contents are only meaningful under the pointers above.
    always_ff @(posedge clk) begin
        if (fire) begin
            pend_pc[pend_wr] <= pc;
        end
        if (rsp_keep) begin
            fifo_pc[fifo_wr]    <= pend_pc[pend_rd];
            fifo_instr[fifo_wr] <= imem_rdata_i;
        end
    end

    always @(posedge clk) begin
        if (rst_n && imem_rvalid_i) begin
            assert (outstanding != '0)
                else $error("fetch_unit: imem_rvalid_i with no outstanding request");
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with configurable
// latency, expected-bundle scoreboard and a table of redirect scenarios.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        out_valid_o;
    logic [31:0] out_instruction_o;
    logic [31:0] out_pc_o;
    logic [31:0] out_pc_plus4_o;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .out_valid_o      (out_valid_o),
        .out_instruction_o(out_instruction_o),
        .out_pc_o         (out_pc_o),
        .out_pc_plus4_o   (out_pc_plus4_o)
    );

    typedef struct { logic [31:0] data; int due; } rsp_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct {
        logic [31:0] target;
        logic        stall;
        int          lat;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc4;
    } vec_t;

    rsp_t        mq[$];
    exp_t        sb[$];
    vec_t        vecs[4];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          lat    = 1;
    logic        gnt_en = 1'b0;
    logic [31:0] model_pc;
    logic [31:0] a0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive memory outputs, sample DUT, update models, advance to next negedge.
    task automatic cycle();
        exp_t e;
        imem_gnt_i = gnt_en;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mq[0].data;
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'hDEAD_BEEF;
        end
        #1;
        if (imem_rvalid_i) mq.delete(0);
        if (imem_req_o && imem_gnt_i) begin
            chk("fetch_addr", imem_addr_o, model_pc);
            mq.push_back('{data: mem_word(imem_addr_o), due: cyc + lat});
            sb.push_back('{pc: model_pc, instr: mem_word(model_pc)});
            model_pc = model_pc + 32'd4;
        end
        if (out_valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got valid pc %08h expected no valid output (cycle %0d)",
                         out_pc_o, cyc);
            end else begin
                e = sb[0];
                chk("out_pc", out_pc_o, e.pc);
                chk("out_instr", out_instruction_o, e.instr);
                chk("out_pc4", out_pc_plus4_o, e.pc + 32'd4);
                if (!stall_i && !redirect_valid_i) sb.delete(0);
            end
        end else begin
            chk("nop_instr", out_instruction_o, NOP);
            chk("nop_pc", out_pc_o, 32'h0);
            chk("nop_pc4", out_pc_plus4_o, 32'h0);
        end
        if (redirect_valid_i) begin
            sb.delete();
            model_pc = {redirect_pc_i[31:2], 2'b00};
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;
        imem_gnt_i       = 1'b0;
        imem_rvalid_i    = 1'b0;
        imem_rdata_i     = 32'h0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("rst_valid", 32'(out_valid_o), 32'h0);
        chk("rst_req", 32'(imem_req_o), 32'h0);
        chk("rst_instr", out_instruction_o, NOP);
        chk("rst_pc", out_pc_o, 32'h0);
        chk("rst_pc4", out_pc_plus4_o, 32'h0);
        chk("rst_addr", imem_addr_o, RESET_PC);
        mq.delete();
        sb.delete();
        model_pc = RESET_PC;
        rst_n    = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid_o && n < 40) begin
            cycle();
            n++;
        end
        if (!out_valid_o) begin
            checks++;
            errors++;
            $display("FAIL %s: out_valid_o stayed 0 for %0d cycles, expected 1", name, n);
        end
    endtask

    initial begin
        vecs[0] = '{target: 32'h0000_0203, stall: 1'b0, lat: 3, exp_addr: 32'h0000_0200, exp_pc4: 32'h0000_0204};
        vecs[1] = '{target: 32'hFFFF_FFFE, stall: 1'b0, lat: 1, exp_addr: 32'hFFFF_FFFC, exp_pc4: 32'h0000_0000};
        vecs[2] = '{target: 32'h0000_1001, stall: 1'b1, lat: 1, exp_addr: 32'h0000_1000, exp_pc4: 32'h0000_1004};
        vecs[3] = '{target: 32'h0000_4000, stall: 1'b1, lat: 2, exp_addr: 32'h0000_4000, exp_pc4: 32'h0000_4004};

        do_reset();

        // Straight-line fetch: gnt always, rvalid one cycle after gnt.
        gnt_en = 1'b1;
        lat    = 1;
        cycle();
        cycle();
        chk("first_valid", 32'(out_valid_o), 32'h1);
        chk("first_pc", out_pc_o, RESET_PC);
        chk("first_instr", out_instruction_o, mem_word(RESET_PC));
        repeat (10) cycle();

        // Held stall: buffer fills, requests stop, output frozen.
        stall_i = 1'b1;
        repeat (5) cycle();
        chk("stall_req", 32'(imem_req_o), 32'h0);
        chk("stall_valid", 32'(out_valid_o), 32'h1);
        stall_i = 1'b0;
        repeat (8) cycle();

        // Grant withheld: address stable, bubbles on output.
        gnt_en = 1'b0;
        repeat (4) cycle();
        a0 = imem_addr_o;
        repeat (3) begin
            cycle();
            chk("hold_addr", imem_addr_o, a0);
            chk("hold_req", 32'(imem_req_o), 32'h1);
            chk("hold_valid", 32'(out_valid_o), 32'h0);
        end
        gnt_en = 1'b1;
        repeat (6) cycle();

        // Redirect scenarios from the vector table.
        for (int i = 0; i < 4; i++) begin
            gnt_en  = 1'b0;
            stall_i = 1'b0;
            repeat (6) cycle();
            lat     = vecs[i].lat;
            gnt_en  = 1'b1;
            stall_i = vecs[i].stall;
            repeat (2) cycle();
            redirect_valid_i = 1'b1;
            redirect_pc_i    = vecs[i].target;
            cycle();
            redirect_valid_i = 1'b0;
            stall_i          = 1'b0;
            chk("redir_addr", imem_addr_o, vecs[i].exp_addr);
            chk("redir_nop", 32'(out_valid_o), 32'h0);
            wait_valid("redir_timeout");
            chk("redir_first_pc", out_pc_o, vecs[i].exp_addr);
            chk("redir_first_pc4", out_pc_plus4_o, vecs[i].exp_pc4);
            chk("redir_first_instr", out_instruction_o, mem_word(vecs[i].exp_addr));
            repeat (6) cycle();
        end

        // Back-to-back redirects with wrong-path responses still in flight.
        gnt_en = 1'b0;
        repeat (6) cycle();
        lat    = 3;
        gnt_en = 1'b1;
        repeat (2) cycle();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h0000_0300;
        cycle();
        redirect_pc_i    = 32'h0000_0400;
        cycle();
        redirect_valid_i = 1'b0;
        chk("b2b_addr", imem_addr_o, 32'h0000_0400);
        wait_valid("b2b_timeout");
        chk("b2b_first_pc", out_pc_o, 32'h0000_0400);
        repeat (8) cycle();

        // Reset with requests in flight.
        lat = 2;
        repeat (3) cycle();
        do_reset();
        gnt_en = 1'b1;
        lat    = 1;
        wait_valid("post_rst_timeout");
        chk("post_rst_pc", out_pc_o, RESET_PC);
        repeat (4) cycle();

        gnt_en = 1'b0;
        repeat (8) cycle();
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
